// File: rtl/hs32_pkg.sv
// hs32_pkg: shared lock-state encoding and default widths for the hs32 register-file arbiter.
package hs32_pkg;
  localparam int HS32_ADDR_WIDTH = 4;
  localparam int HS32_DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } lock_t;
endpackage

// File: rtl/hs32_regarb_pick.sv
// hs32_regarb_pick: combinational one-hot grant for two clients; HS32_REGARB_RR_EN selects round-robin conflicts.
module hs32_regarb_pick
  import hs32_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  lock_t      state,
`ifdef HS32_REGARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] grant
);
  logic win1;
`ifdef HS32_REGARB_RR_EN
  assign win1 = ~last;
`else
  assign win1 = 1'b0;
`endif
  // The unused state code 2'd3 falls through to unlocked arbitration.
  always_comb
    grant = state == OWN0 ? {1'b0, valid0} :
            state == OWN1 ? {valid1, 1'b0} :
            (valid0 & valid1) ? (win1 ? 2'b10 : 2'b01) :
            {valid1, valid0};
endmodule

// File: rtl/hs32_regarb.sv
// hs32_regarb: two-client arbiter/sequencer for a dual-read/single-write register file.
// Build option: define HS32_REGARB_RR_EN for round-robin conflicts (fixed client-0 priority otherwise).
module hs32_regarb
  import hs32_pkg::*;
#(
  parameter int ADDR_WIDTH = HS32_ADDR_WIDTH,
  parameter int DATA_WIDTH = HS32_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_valid,
  output logic                  c0_ready,
  input  logic                  c0_we,
  input  logic                  c0_lock,
  input  logic [ADDR_WIDTH-1:0] c0_wadr,
  input  logic [DATA_WIDTH-1:0] c0_din,
  input  logic [ADDR_WIDTH-1:0] c0_radr1,
  input  logic [ADDR_WIDTH-1:0] c0_radr2,
  output logic                  c0_rvalid,
  input  logic                  c1_valid,
  output logic                  c1_ready,
  input  logic                  c1_we,
  input  logic                  c1_lock,
  input  logic [ADDR_WIDTH-1:0] c1_wadr,
  input  logic [DATA_WIDTH-1:0] c1_din,
  input  logic [ADDR_WIDTH-1:0] c1_radr1,
  input  logic [ADDR_WIDTH-1:0] c1_radr2,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wadr,
  output logic [ADDR_WIDTH-1:0] rf_radr1,
  output logic [ADDR_WIDTH-1:0] rf_radr2,
  output logic [DATA_WIDTH-1:0] rf_din,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2
);
  lock_t       state;
  logic [1:0]  grant;
  logic [1:0]  g;
  logic        sel1;
  logic        lk;
`ifdef HS32_REGARB_RR_EN
  logic        last;
`endif
  hs32_regarb_pick u_pick (
    .valid0 (c0_valid),
    .valid1 (c1_valid),
    .state  (state),
`ifdef HS32_REGARB_RR_EN
    .last   (last),
`endif
    .grant  (grant)
  );
  // Reset gates the grant so nothing reaches the file while reset is low.
  assign g        = grant & {2{reset}};
  assign sel1     = grant[1];
  assign c0_ready = g[0];
  assign c1_ready = g[1];
  assign lk       = sel1 ? c1_lock : c0_lock;
  assign rf_we    = |g & (sel1 ? c1_we : c0_we);
  assign rf_wadr  = sel1 ? c1_wadr : c0_wadr;
  assign rf_din   = sel1 ? c1_din : c0_din;
  assign rf_radr1 = sel1 ? c1_radr1 : c0_radr1;
  assign rf_radr2 = sel1 ? c1_radr2 : c0_radr2;
  assign rdata1   = rf_dout1;
  assign rdata2   = rf_dout2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= UNLOCKED;
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
`ifdef HS32_REGARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      c0_rvalid <= g[0] & ~c0_we;
      c1_rvalid <= g[1] & ~c1_we;
      if (|g) begin
        state <= lk ? (sel1 ? OWN1 : OWN0) : UNLOCKED;
`ifdef HS32_REGARB_RR_EN
        last  <= sel1;
`endif
      end
    end
endmodule
